// File: rtl/d_ff_if.sv
// Data bundle for the d_ff storage element: D in, registered Q (and Qn) out.
// Qn exists only when DFF_QN_EN is defined.
interface d_ff_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
`ifdef DFF_QN_EN
  logic [WIDTH-1:0] Qn;
`endif

`ifdef DFF_QN_EN
  modport master (output D, input Q, input Qn);
  modport slave  (input D, output Q, output Qn);
`else
  modport master (output D, input Q);
  modport slave  (input D, output Q);
`endif
endinterface

// File: rtl/d_ff.sv
// WIDTH-bit D flip-flop with synchronous active-low reset to RESET_VAL.
// Optional feature macro DFF_QN_EN adds a registered inverted output Qn.
module d_ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic  clock,
  input  logic  reset,
  d_ff_if.slave bus
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Reset wins over D whenever both are presented at the same edge.
  always_comb begin
    q_d = bus.D;
    if (!reset) begin
      q_d = RESET_VAL;
    end
  end

  always_ff @(posedge clock) begin
    q_q <= q_d;
  end

  assign bus.Q = q_q;

`ifdef DFF_QN_EN
  logic [WIDTH-1:0] qn_q;

  // Separate register so Qn is a flop output, not an inverter after Q.
  always_ff @(posedge clock) begin
    qn_q <= ~q_d;
  end

  assign bus.Qn = qn_q;
`endif

endmodule

// File: tb/tb_d_ff.sv
// Directed bench for d_ff: a 1-bit/RESET_VAL=0 and an 8-bit/RESET_VAL=A5 instance
// side by side, checked every cycle against a sample-and-hold model.
module tb_d_ff;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   edge_no;

  d_ff_if #(.WIDTH(1)) bus1 ();
  d_ff_if #(.WIDTH(8)) bus8 ();

  d_ff #(.WIDTH(1), .RESET_VAL(1'b0)) u_dff1 (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus1.slave)
  );

  d_ff #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dff8 (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: Q after an edge is whatever the rules select from the inputs seen at that edge.
  logic       model_valid;
  logic       exp_q1;
  logic [7:0] exp_q8;

  initial model_valid = 1'b0;

  always @(posedge clk) begin
    exp_q1      <= rst_n ? bus1.D : 1'b0;
    exp_q8      <= rst_n ? bus8.D : 8'hA5;
    model_valid <= 1'b1;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, mid-period so Q has settled after the preceding edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("q1_model", {7'b0, bus1.Q}, {7'b0, exp_q1});
      check("q8_model", bus8.Q, exp_q8);
`ifdef DFF_QN_EN
      check("qn1_model", {7'b0, bus1.Qn}, {7'b0, ~exp_q1});
      check("qn8_model", bus8.Qn, ~exp_q8);
`endif
    end
  end

  // Present inputs, wait for the edge that samples them, return 1 time unit later.
  task automatic drive(input logic r, input logic d1, input logic [7:0] d8);
    rst_n  = r;
    bus1.D = d1;
    bus8.D = d8;
    @(posedge clk);
    #1;
    edge_no++;
    $display("edge %0d: reset=%b D1=%b D8=%h -> Q1=%b Q8=%h",
             edge_no, r, d1, d8, bus1.Q, bus8.Q);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    edge_no  = 0;

    // Reset held low with D=1: Q pinned to RESET_VAL for every edge.
    for (int i = 0; i < 50; i++) begin
      drive(1'b0, 1'b1, 8'hFF);
    end
    check("reset_hold_q1", {7'b0, bus1.Q}, 8'h00);
    check("reset_hold_q8", bus8.Q, 8'hA5);
`ifdef DFF_QN_EN
    check("reset_hold_qn8", bus8.Qn, 8'h5A);
`endif

    // D toggled every two periods: Q follows D one edge later.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'((i / 2) % 2), 8'(i * 17));
    end
    check("toggle_last_q1", {7'b0, bus1.Q}, 8'h01);
    check("toggle_last_q8", bus8.Q, 8'hFF);

    // Steady D=1, then a single reset edge discards it.
    drive(1'b1, 1'b1, 8'h3C);
    drive(1'b1, 1'b1, 8'h3C);
    check("load_q1", {7'b0, bus1.Q}, 8'h01);
    check("load_q8", bus8.Q, 8'h3C);
`ifdef DFF_QN_EN
    check("load_qn8", bus8.Qn, 8'hC3);
`endif
    drive(1'b0, 1'b1, 8'h3C);
    check("reset_pulse_q1", {7'b0, bus1.Q}, 8'h00);
    check("reset_pulse_q8", bus8.Q, 8'hA5);

    // Release reset with D=1 already present: first released edge loads D.
    drive(1'b1, 1'b1, 8'h81);
    check("release_q1", {7'b0, bus1.Q}, 8'h01);
    check("release_q8", bus8.Q, 8'h81);

    // Glitch on D strictly between edges must not reach Q.
    drive(1'b1, 1'b0, 8'h00);
    check("pre_glitch_q1", {7'b0, bus1.Q}, 8'h00);
    bus1.D = 1'b1;
    bus8.D = 8'hFF;
    #2;
    bus1.D = 1'b0;
    bus8.D = 8'h00;
    check("mid_glitch_q1", {7'b0, bus1.Q}, 8'h00);
    check("mid_glitch_q8", bus8.Q, 8'h00);
    @(posedge clk);
    #1;
    edge_no++;
    $display("edge %0d: glitch edge -> Q1=%b Q8=%h", edge_no, bus1.Q, bus8.Q);
    check("post_glitch_q1", {7'b0, bus1.Q}, 8'h00);
    check("post_glitch_q8", bus8.Q, 8'h00);

    // Mixed traffic with occasional reset, checked by the model alone.
    for (int i = 0; i < 40; i++) begin
      drive(($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom));
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
